// File: rtl/regfile_writeback_arbiter.sv
// Round-robin write-back arbiter for ALU/mem/IO into the register-file demux; one-cycle latency.
// Backpressure: stall freezes the output register and drops every req_ready until it can drain.
module regfile_writeback_arbiter #(
  parameter int WIDTH = 20,
  parameter int AW    = 4,
  parameter int NREQ  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  stall,
  output logic [WIDTH-1:0]      dmx_in,
  output logic [AW-1:0]         dmx_addr,
  output logic [2**AW-1:0]      wr_en,
  output logic                  wr_valid,
  output logic [NREQ-1:0]       last_grant,
  output logic [15:0]           conflict_cnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]  ptr;
  logic [NREQ-1:0]  win_oh;
  logic             found;
  logic             can_load;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;
  logic [AW-1:0]    sel_addr;
  logic             conflict;

  assign can_load = !wr_valid || !stall;
  assign conflict = ($countones(req_valid) >= 2);

  // Search begins one past the last winner and wraps, so the previous winner is checked last.
  always_comb begin
    int ptr_i;
    ptr_i  = 0;
    found  = 1'b0;
    win_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (ptr[i]) ptr_i = i;
    end
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (ptr_i + k) % NREQ;
      if (!found && req_valid[c[IW-1:0]]) begin
        found              = 1'b1;
        win_oh[c[IW-1:0]]  = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_oh[i]) begin
        sel_data = req_data[i*WIDTH +: WIDTH];
        sel_addr = req_addr[i*AW +: AW];
      end
    end
  end

  assign xfer      = can_load && found && !rst;
  assign req_ready = xfer ? win_oh : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_valid     <= 1'b0;
      dmx_in       <= '0;
      dmx_addr     <= '0;
      ptr          <= NREQ'(1) << (NREQ - 1);
      conflict_cnt <= '0;
    end else begin
      if (conflict && (conflict_cnt != 16'hFFFF)) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
      if (xfer) begin
        wr_valid <= 1'b1;
        dmx_in   <= sel_data;
        dmx_addr <= sel_addr;
        ptr      <= win_oh;
      end else if (can_load) begin
        wr_valid <= 1'b0;
      end
    end
  end

  // The pointer always holds the latest accepted requester.
  assign last_grant = ptr;

  always_comb begin
    wr_en = '0;
    if (wr_valid) wr_en[dmx_addr] = 1'b1;
  end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for regfile_writeback_arbiter with hand-computed expected values.
module tb_regfile_writeback_arbiter;
  localparam int WIDTH = 20;
  localparam int AW    = 4;
  localparam int NREQ  = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  stall;
  logic [WIDTH-1:0]      dmx_in;
  logic [AW-1:0]         dmx_addr;
  logic [2**AW-1:0]      wr_en;
  logic                  wr_valid;
  logic [NREQ-1:0]       last_grant;
  logic [15:0]           conflict_cnt;

  int errors = 0;
  int checks = 0;

  regfile_writeback_arbiter #(.WIDTH(WIDTH), .AW(AW), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .stall(stall),
    .dmx_in(dmx_in), .dmx_addr(dmx_addr), .wr_en(wr_en), .wr_valid(wr_valid),
    .last_grant(last_grant), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reqs(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                          input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2);
    req_addr = {a2, a1, a0};
    req_data = {d2, d1, d0};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [2:0]  exp_grant [6];
  logic [15:0] exp_wen   [6];

  initial begin
    rst = 1'b1;
    req_valid = '0;
    stall = 1'b0;
    set_reqs(4'd0, 4'd0, 4'd0, 20'h0, 20'h0, 20'h0);

    // reset state, ready held low while rst is high
    req_valid = 3'b111;
    tick();
    tick();
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_wr_valid", 32'(wr_valid), 32'h0);
    check("rst_dmx_in", 32'(dmx_in), 32'h0);
    check("rst_dmx_addr", 32'(dmx_addr), 32'h0);
    check("rst_wr_en", 32'(wr_en), 32'h0);
    check("rst_last_grant", 32'(last_grant), 32'h4);
    check("rst_conflict", 32'(conflict_cnt), 32'h0);
    req_valid = '0;
    rst = 1'b0;
    tick();

    // ALU only, addr 5
    set_reqs(4'd5, 4'd0, 4'd0, 20'h12345, 20'h0, 20'h0);
    req_valid = 3'b001;
    #1;
    check("alu_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    check("alu_wr_valid", 32'(wr_valid), 32'h1);
    check("alu_dmx_addr", 32'(dmx_addr), 32'h5);
    check("alu_dmx_in", 32'(dmx_in), 32'h12345);
    check("alu_wr_en", 32'(wr_en), 32'h0020);
    check("alu_last_grant", 32'(last_grant), 32'h1);
    tick();
    check("alu_drain_valid", 32'(wr_valid), 32'h0);
    check("alu_drain_wr_en", 32'(wr_en), 32'h0);
    check("alu_no_conflict", 32'(conflict_cnt), 32'h0);

    // all three valid for 6 cycles from a fresh pointer
    do_reset();
    exp_grant = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    exp_wen   = '{16'h0002, 16'h0004, 16'h0008, 16'h0002, 16'h0004, 16'h0008};
    set_reqs(4'd1, 4'd2, 4'd3, 20'h11111, 20'h22222, 20'h33333);
    req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("rr_grant%0d", i), 32'(last_grant), 32'(exp_grant[i]));
      check($sformatf("rr_wr_en%0d", i), 32'(wr_en), 32'(exp_wen[i]));
      if (i == 1) check("rr_dmx_in1", 32'(dmx_in), 32'h22222);
    end
    req_valid = '0;
    check("rr_conflict", 32'(conflict_cnt), 32'd6);
    tick();
    check("rr_drain", 32'(wr_valid), 32'h0);

    // stall held 3 cycles on a write to addr 15
    set_reqs(4'd15, 4'd2, 4'd3, 20'hABCDE, 20'h22222, 20'h33333);
    req_valid = 3'b001;
    tick();
    set_reqs(4'd1, 4'd2, 4'd3, 20'h11111, 20'h22222, 20'h33333);
    stall = 1'b1;
    req_valid = 3'b111;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall_wr_en%0d", i), 32'(wr_en), 32'h8000);
      check($sformatf("stall_ready%0d", i), 32'(req_ready), 32'h0);
      tick();
    end
    check("stall_wr_en3", 32'(wr_en), 32'h8000);
    check("stall_dmx_in", 32'(dmx_in), 32'hABCDE);
    check("stall_ptr_held", 32'(last_grant), 32'h1);
    stall = 1'b0;
    #1;
    check("stall_release_ready", 32'(req_ready), 32'h2);
    tick();
    check("resume_g0", 32'(last_grant), 32'h2);
    tick();
    check("resume_g1", 32'(last_grant), 32'h4);
    tick();
    check("resume_g2", 32'(last_grant), 32'h1);
    req_valid = '0;
    tick();

    // memory and I/O after an ALU grant; ALU joins mid-sequence
    req_valid = 3'b110;
    #1;
    check("mi_ready0", 32'(req_ready), 32'h2);
    tick();
    check("mi_grant0", 32'(last_grant), 32'h2);
    req_valid = 3'b111;
    #1;
    check("mi_ready1", 32'(req_ready), 32'h4);
    tick();
    check("mi_grant1", 32'(last_grant), 32'h4);
    #1;
    check("mi_ready2", 32'(req_ready), 32'h1);
    tick();
    check("mi_grant2", 32'(last_grant), 32'h1);

    // reset while a write is pending under stall
    stall = 1'b1;
    rst = 1'b1;
    tick();
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    check("mid_rst_wr_valid", 32'(wr_valid), 32'h0);
    check("mid_rst_wr_en", 32'(wr_en), 32'h0);
    check("mid_rst_dmx_in", 32'(dmx_in), 32'h0);
    check("mid_rst_dmx_addr", 32'(dmx_addr), 32'h0);
    check("mid_rst_conflict", 32'(conflict_cnt), 32'h0);
    check("mid_rst_grant", 32'(last_grant), 32'h4);
    rst = 1'b0;
    stall = 1'b0;
    req_valid = '0;
    tick();

    // conflict counter saturation with two continuous requesters
    req_valid = 3'b011;
    repeat (65534) tick();
    check("sat_fffe", 32'(conflict_cnt), 32'hFFFE);
    tick();
    check("sat_ffff", 32'(conflict_cnt), 32'hFFFF);
    repeat (3) tick();
    check("sat_hold", 32'(conflict_cnt), 32'hFFFF);
    req_valid = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
